// File: rtl/spi_ip_flag_ctrl_pkg.sv
// Shared types for the flag-sync channel scheduler: controller state encoding.
package spi_ip_flag_ctrl_pkg;

    localparam int FC_STATE_W = 3;

    typedef enum logic [FC_STATE_W-1:0] {
        FC_IDLE      = 3'd0,
        FC_ISSUE     = 3'd1,
        FC_WAIT_DROP = 3'd2,
        FC_WAIT_ACK  = 3'd3,
        FC_RECOVER   = 3'd4
    } fc_state_e;

endpackage

// File: rtl/spi_ip_rr_arbiter.sv
// Combinational round-robin pick: first pending requester strictly after the
// last granted index, wrapping around.
module spi_ip_rr_arbiter #(
    parameter int PARAM_NUM_REQ = 4
) (
    input  logic [PARAM_NUM_REQ-1:0]         pending,
    input  logic [$clog2(PARAM_NUM_REQ)-1:0] last_grant,
    output logic [$clog2(PARAM_NUM_REQ)-1:0] winner,
    output logic                             any_valid
);

    localparam int TW = $clog2(PARAM_NUM_REQ);

    always_comb begin
        int               idx;
        logic [TW-1:0]    sel;
        idx       = 0;
        sel       = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= PARAM_NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= PARAM_NUM_REQ) begin
                idx = idx - PARAM_NUM_REQ;
            end
            sel = TW'(idx);
            if (!any_valid && pending[sel]) begin
                any_valid = 1'b1;
                winner    = sel;
            end
        end
    end

endmodule

// File: rtl/spi_ip_flag_ctrl.sv
// Round-robin scheduler that shares one flag-sync CDC channel between several
// requesters: latches request pulses, issues one set pulse + tag, waits for the round trip, acks.
module spi_ip_flag_ctrl
    import spi_ip_flag_ctrl_pkg::*;
#(
    parameter int PARAM_NUM_REQ   = 4,
    parameter int PARAM_TIMEOUT   = 255,
    parameter int PARAM_CNT_WIDTH = 8
) (
    input  logic                             fc_clk_i,
    input  logic                             fc_rst_n_i,
    input  logic                             fc_en_i,
    input  logic [PARAM_NUM_REQ-1:0]         fc_req_i,
    input  logic                             fc_flag_valid_i,
    input  logic                             fc_clr_timeout_i,
    output logic                             fc_set_flag_o,
    output logic [$clog2(PARAM_NUM_REQ)-1:0] fc_tag_o,
    output logic [PARAM_NUM_REQ-1:0]         fc_ack_o,
    output logic [PARAM_NUM_REQ-1:0]         fc_pending_o,
    output logic                             fc_busy_o,
    output logic                             fc_timeout_o
);

    localparam int TW = $clog2(PARAM_NUM_REQ);
    localparam bit TO_EN = (PARAM_TIMEOUT != 0);
    localparam logic [PARAM_CNT_WIDTH-1:0] TO_LAST =
        PARAM_CNT_WIDTH'((PARAM_TIMEOUT > 0) ? PARAM_TIMEOUT - 1 : 0);

    generate
        if (PARAM_NUM_REQ < 2 || PARAM_NUM_REQ > 16) begin : g_bad_num_req
            $error("spi_ip_flag_ctrl: PARAM_NUM_REQ must be 2..16");
        end
        if (PARAM_TIMEOUT >= (1 << PARAM_CNT_WIDTH)) begin : g_bad_cnt_width
            $error("spi_ip_flag_ctrl: PARAM_CNT_WIDTH too small for PARAM_TIMEOUT");
        end
    endgenerate

    fc_state_e                   state_q;
    logic [PARAM_NUM_REQ-1:0]    pending_q;
    logic [TW-1:0]               rr_ptr_q;
    logic [PARAM_CNT_WIDTH-1:0]  cnt_q;

    logic [TW-1:0]               arb_winner;
    logic                        arb_any;
    logic [PARAM_NUM_REQ-1:0]    tag_onehot;
    logic [PARAM_NUM_REQ-1:0]    clr_issue;
    logic                        to_hit;
    logic                        in_wait;

    spi_ip_rr_arbiter #(
        .PARAM_NUM_REQ (PARAM_NUM_REQ)
    ) u_arb (
        .pending    (pending_q),
        .last_grant (rr_ptr_q),
        .winner     (arb_winner),
        .any_valid  (arb_any)
    );

    always_comb begin
        tag_onehot           = '0;
        tag_onehot[fc_tag_o] = 1'b1;
    end

    assign clr_issue = (state_q == FC_ISSUE) ? tag_onehot : '0;
    assign in_wait   = (state_q == FC_WAIT_DROP) || (state_q == FC_WAIT_ACK);
    assign to_hit    = TO_EN && in_wait && (cnt_q == TO_LAST);

    // A request landing on the issue cycle wins over the clear, so it is queued again.
    always_ff @(posedge fc_clk_i or negedge fc_rst_n_i) begin
        if (!fc_rst_n_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_issue) | fc_req_i;
        end
    end

    assign fc_pending_o = pending_q;

    always_ff @(posedge fc_clk_i or negedge fc_rst_n_i) begin
        if (!fc_rst_n_i) begin
            state_q       <= FC_IDLE;
            rr_ptr_q      <= TW'(PARAM_NUM_REQ - 1);
            cnt_q         <= '0;
            fc_set_flag_o <= 1'b0;
            fc_tag_o      <= '0;
            fc_ack_o      <= '0;
            fc_busy_o     <= 1'b0;
            fc_timeout_o  <= 1'b0;
        end else begin
            fc_set_flag_o <= 1'b0;
            fc_ack_o      <= '0;
            case (state_q)
                FC_IDLE: begin
                    if (fc_en_i && fc_flag_valid_i && arb_any) begin
                        state_q       <= FC_ISSUE;
                        fc_tag_o      <= arb_winner;
                        rr_ptr_q      <= arb_winner;
                        fc_set_flag_o <= 1'b1;
                        fc_busy_o     <= 1'b1;
                    end
                end
                FC_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= FC_WAIT_DROP;
                end
                FC_WAIT_DROP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (to_hit) begin
                        state_q <= FC_RECOVER;
                    end else if (!fc_flag_valid_i) begin
                        state_q <= FC_WAIT_ACK;
                    end
                end
                FC_WAIT_ACK: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (to_hit) begin
                        state_q <= FC_RECOVER;
                    end else if (fc_flag_valid_i) begin
                        state_q   <= FC_IDLE;
                        fc_busy_o <= 1'b0;
                        fc_ack_o  <= tag_onehot;
                    end
                end
                FC_RECOVER: begin
                    // Aborted transfer: let the channel settle back to idle, no ack.
                    if (fc_flag_valid_i) begin
                        state_q   <= FC_IDLE;
                        fc_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= FC_IDLE;
                    fc_busy_o <= 1'b0;
                end
            endcase
            if (to_hit) begin
                fc_timeout_o <= 1'b1;
            end else if (fc_clr_timeout_i) begin
                fc_timeout_o <= 1'b0;
            end
        end
    end

endmodule
